// File: rtl/multiport_register_file.sv
`default_nettype none
// ============================================================================
// Module      : multiport_register_file
// Description : Byte-enabled register file with NUM_RD registered read ports,
//               optional write-to-read bypass and a hardware clear sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module multiport_register_file #(
    parameter  int DEPTH  = 8,
    parameter  int WIDTH  = 16,
    parameter  int NUM_RD = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(DEPTH),
    localparam int BW     = WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_req,
    output logic                    clr_busy,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [BW-1:0]           wr_be,
    input  logic [NUM_RD-1:0]       rd_en,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_valid
);

    localparam logic [AW:0]   c_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_LAST  = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [AW-1:0]      r_clr_ptr;
    logic [AW-1:0]      w_clr_ptr_next;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [WIDTH-1:0]   r_rd_data [NUM_RD];
    logic [NUM_RD-1:0]  r_rd_valid;
    logic [WIDTH-1:0]   w_rd_word [NUM_RD];
    logic [AW-1:0]      w_rd_addr [NUM_RD];

    logic               w_wr_in_range;
    logic               w_wr_ok;
    logic [WIDTH-1:0]   w_wr_old;
    logic [WIDTH-1:0]   w_wr_merged;

    // ------------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_ptr <= w_clr_ptr_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_ptr_next = r_clr_ptr;
        case (r_state)
            S_IDLE: begin
                if (clr_req) begin
                    w_state_next   = S_CLEAR;
                    w_clr_ptr_next = '0;
                end
            end
            S_CLEAR: begin
                if (r_clr_ptr == c_LAST) begin
                    w_state_next   = S_IDLE;
                    w_clr_ptr_next = '0;
                end else begin
                    w_clr_ptr_next = r_clr_ptr + AW'(1);
                end
            end
            default: begin
                w_state_next   = S_CLEAR;
                w_clr_ptr_next = '0;
            end
        endcase
    end

    assign clr_busy = (r_state == S_CLEAR);

    // ------------------------------------------------------------------------
    // Write path: byte merge against the current contents of the target entry
    // ------------------------------------------------------------------------
    always_comb begin
        w_wr_in_range = ({1'b0, wr_addr} < c_DEPTH);
        w_wr_ok       = (r_state == S_IDLE) && wr_en && w_wr_in_range && (|wr_be);
        w_wr_old      = w_wr_in_range ? r_mem[wr_addr] : '0;
        w_wr_merged   = w_wr_old;
        for (int b = 0; b < BW; b++) begin
            if (wr_be[b]) begin
                w_wr_merged[b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
    end

    // Storage is not reset; the clear sequence zeroes it after reset.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= w_wr_merged;
        end
    end

    // ------------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------------
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            w_rd_word[p] = '0;
            if ((r_state == S_CLEAR) || ({1'b0, w_rd_addr[p]} >= c_DEPTH)) begin
                w_rd_word[p] = '0;
            end else if ((BYPASS != 0) && w_wr_ok && (w_rd_addr[p] == wr_addr)) begin
                w_rd_word[p] = w_wr_merged;
            end else begin
                w_rd_word[p] = r_mem[w_rd_addr[p]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= '0;
            for (int p = 0; p < NUM_RD; p++) begin
                r_rd_data[p] <= '0;
            end
        end else begin
            r_rd_valid <= rd_en;
            for (int p = 0; p < NUM_RD; p++) begin
                if (rd_en[p]) begin
                    r_rd_data[p] <= w_rd_word[p];
                end
            end
        end
    end

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
            assign w_rd_addr[p]                = rd_addr[p*AW +: AW];
            assign rd_data[p*WIDTH +: WIDTH]   = r_rd_data[p];
        end
    endgenerate

    assign rd_valid = r_rd_valid;

endmodule
`default_nettype wire
